gbclk_capture: RTL and testbench

Parametrised successor of the single-channel DMG clock generator. Drives the Game Boy oscillator input (X1) from the FPGA clock with a runtime-programmable period, counts delivered ticks, and timestamps the first bus access on each of CHANNELS programmable address/direction comparators. Sits between the PLL clock domain, the registered cartridge-bus inputs and the LED/readout logic. Supports stop-at-tick-alignment and a single-step mode.

---
 rtl/gbclk_capture.sv | 194 +++++++++++++++++++
 tb/tb_gbclk_capture.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gbclk_capture.sv
// Programmable X1 clock generator with tick counter and per-channel bus-access timestamps.
// Optional single-step mode is compiled in when GBCLK_STEP_EN is defined.
module gbclk_capture #(
  parameter int CNT_WIDTH = 32,
  parameter int DIV_WIDTH = 4,
  parameter int CHANNELS  = 4,
  parameter int ADR_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          clear,
  input  logic                          start,
  input  logic                          stop_req,
  input  logic [1:0]                    align,
  input  logic                          step,
  input  logic [DIV_WIDTH-1:0]          half_period,
  input  logic [ADR_WIDTH-1:0]          adr,
  input  logic                          n_rd,
  input  logic                          n_wr,
  input  logic [CHANNELS*ADR_WIDTH-1:0] match_adr,
  input  logic [CHANNELS-1:0]           match_wr,
  output logic                          clkout,
  output logic                          tick,
  output logic                          running,
  output logic [CNT_WIDTH-1:0]          count,
  output logic [CHANNELS-1:0]           hit,
  output logic [CHANNELS*CNT_WIDTH-1:0] hit_at
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
`ifdef GBCLK_STEP_EN
    , S_STEP   = 2'd3
`endif
  } state_t;

  state_t                        state_q, state_d;
  logic [DIV_WIDTH-1:0]          phase_q, hp_q;
  logic                          clkout_q, tick_q, stop_pend_q;
  logic [CNT_WIDTH-1:0]          count_q;
  logic [CHANNELS-1:0]           hit_q;
  logic [CHANNELS*CNT_WIDTH-1:0] hit_at_q;

  logic                 active_s, toggle_s, rise_s, stop_arm_s, running_s;
  logic [CNT_WIDTH-1:0] cnt_inc_s;
  logic [CHANNELS-1:0]  match_s;

`ifndef GBCLK_STEP_EN
  logic unused_step_s;
  assign unused_step_s = step;
`endif

  assign active_s   = (state_q != S_IDLE);
  assign toggle_s   = active_s && (phase_q == hp_q);
  assign rise_s     = toggle_s && !clkout_q;
  assign cnt_inc_s  = count_q + CNT_WIDTH'(1);
  assign stop_arm_s = (stop_pend_q || stop_req) && !start;

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides everything
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
`ifdef GBCLK_STEP_EN
          end else if (step) begin
            state_d = S_STEP;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          if (rise_s && (cnt_inc_s[1:0] == align) && stop_arm_s) begin
            state_d = S_STOPPING;
          end else begin
            state_d = S_RUN;
          end
        end
        // Entered on a rise, so the next toggle is always the falling one
        S_STOPPING: begin
          if (toggle_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_STOPPING;
          end
        end
`ifdef GBCLK_STEP_EN
        S_STEP: begin
          if (toggle_s && clkout_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_STEP;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    running_s = 1'b0;
    if (state_q != S_IDLE) begin
      running_s = 1'b1;
    end else begin
      running_s = 1'b0;
    end
  end

  // Channel comparators, qualified by the rising tick
  always_comb begin
    match_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      match_s[i] = rise_s && !hit_q[i] && (adr == match_adr[i*ADR_WIDTH +: ADR_WIDTH]) &&
                   (match_wr[i] ? !n_wr : !n_rd);
    end
  end

  // Divider, counter, stop latch and hit capture
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      phase_q     <= '0;
      hp_q        <= '0;
      clkout_q    <= 1'b0;
      tick_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      count_q     <= '0;
      hit_q       <= '0;
      hit_at_q    <= '0;
    end else if (clear) begin
      phase_q     <= '0;
      hp_q        <= '0;
      clkout_q    <= 1'b0;
      tick_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      count_q     <= '0;
      hit_q       <= '0;
      hit_at_q    <= '0;
    end else begin
      tick_q <= rise_s;
      // half_period is re-latched only at half-period boundaries
      if (!active_s) begin
        phase_q  <= '0;
        clkout_q <= 1'b0;
        hp_q     <= half_period;
      end else if (toggle_s) begin
        phase_q  <= '0;
        clkout_q <= !clkout_q;
        hp_q     <= half_period;
      end else begin
        phase_q  <= phase_q + DIV_WIDTH'(1);
      end
      if (rise_s) begin
        count_q <= cnt_inc_s;
      end
      if ((state_q == S_RUN) && (state_d == S_RUN)) begin
        stop_pend_q <= start ? 1'b0 : (stop_pend_q || stop_req);
      end else begin
        stop_pend_q <= 1'b0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (match_s[i]) begin
          hit_q[i]                             <= 1'b1;
          hit_at_q[i*CNT_WIDTH +: CNT_WIDTH]   <= count_q;
        end
      end
    end
  end

  assign clkout  = clkout_q;
  assign tick    = tick_q;
  assign running = running_s;
  assign count   = count_q;
  assign hit     = hit_q;
  assign hit_at  = hit_at_q;

endmodule

// File: tb/tb_gbclk_capture.sv
// Directed self-checking bench for gbclk_capture (default build and GBCLK_STEP_EN build).
module tb_gbclk_capture;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        clear = 1'b0, start = 1'b0, stop_req = 1'b0, step = 1'b0;
  logic [1:0]  align = 2'd0;
  logic [3:0]  half_period = 4'd3;
  logic [15:0] adr = 16'h0000;
  logic        n_rd = 1'b1, n_wr = 1'b1;
  logic [63:0] match_adr = {16'hFFFF, 16'hFFFF, 16'hFF50, 16'h0100};
  logic [3:0]  match_wr = 4'b1110;

  logic         clkout, tick, running;
  logic [31:0]  count;
  logic [3:0]   hit;
  logic [127:0] hit_at;
  logic         s_clkout, s_tick, s_running;
  logic [3:0]   s_count;
  logic [3:0]   s_hit;
  logic [15:0]  s_hit_at;

  int n_cmp = 0, n_err = 0;
  int ticks_seen = 0, tick_bad = 0;
  logic prev_ck = 1'b0;
  int n, first_rise, high_cnt;

  gbclk_capture dut (
    .clk(clk), .n_reset(n_reset), .clear(clear), .start(start), .stop_req(stop_req),
    .align(align), .step(step), .half_period(half_period), .adr(adr), .n_rd(n_rd),
    .n_wr(n_wr), .match_adr(match_adr), .match_wr(match_wr), .clkout(clkout),
    .tick(tick), .running(running), .count(count), .hit(hit), .hit_at(hit_at)
  );

  gbclk_capture #(.CNT_WIDTH(4)) dut_small (
    .clk(clk), .n_reset(n_reset), .clear(clear), .start(start), .stop_req(stop_req),
    .align(align), .step(step), .half_period(half_period), .adr(adr), .n_rd(n_rd),
    .n_wr(n_wr), .match_adr(match_adr), .match_wr(match_wr), .clkout(s_clkout),
    .tick(s_tick), .running(s_running), .count(s_count), .hit(s_hit), .hit_at(s_hit_at)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1 time unit after the edge; tracks tick vs. clkout rise.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (tick) ticks_seen++;
    if (tick !== (clkout && !prev_ck)) tick_bad++;
    prev_ck = clkout;
  endtask

  task automatic wait_level(input logic lvl, input string tag);
    int k = 0;
    while (clkout !== lvl && k < 200) begin
      cyc();
      k++;
    end
    if (k >= 200) check_val({tag, "_timeout"}, 64'(clkout), 64'(lvl));
  endtask

  task automatic run_len(input logic lvl, output int len);
    len = 0;
    while (clkout === lvl && len < 100) begin
      cyc();
      len++;
    end
  endtask

  task automatic wait_count(input logic [31:0] target, input string tag);
    int k = 0;
    while (count !== target && k < 6000) begin
      cyc();
      k++;
    end
    if (k >= 6000) check_val({tag, "_timeout"}, 64'(count), 64'(target));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    check_val("rst_clkout", 64'(clkout), 64'd0);
    check_val("rst_running", 64'(running), 64'd0);
    check_val("rst_count", 64'(count), 64'd0);
    check_val("rst_hit", 64'(hit), 64'd0);
    check_val("rst_tick", 64'(tick), 64'd0);
    n_reset = 1'b1;
    cyc();

    // 20 ticks at half_period = 3
    half_period = 4'd3;
    pulse_start();
    check_val("start_running", 64'(running), 64'd1);
    check_val("start_clkout", 64'(clkout), 64'd0);
    first_rise = 0;
    high_cnt = 0;
    ticks_seen = 0;
    for (int j = 1; j <= 160; j++) begin
      cyc();
      if (clkout && first_rise == 0) first_rise = j;
      if (clkout) high_cnt++;
    end
    check_val("first_rise", 64'(first_rise), 64'd4);
    check_val("high_cycles", 64'(high_cnt), 64'd80);
    check_val("ticks20", 64'(ticks_seen), 64'd20);
    check_val("count20", 64'(count), 64'd20);
    check_val("tick_align20", 64'(tick_bad), 64'd0);

    // half_period 3 -> 0 during a high phase
    wait_level(1'b1, "hp_rise");
    cyc();
    half_period = 4'd0;
    run_len(1'b1, n);
    check_val("hp_cur_high", 64'(n + 1), 64'd4);
    run_len(1'b0, n);
    check_val("hp_next_low", 64'(n), 64'd1);
    run_len(1'b1, n);
    check_val("hp_next_high", 64'(n), 64'd1);

    // Read of 0x0100 on the tick that leaves count 1234
    wait_count(32'd1234, "wc1234");
    adr = 16'h0100; n_rd = 1'b0;
    cyc();
    cyc();
    n_rd = 1'b1; adr = 16'h0000;
    check_val("hit_first", 64'(hit), 64'h1);
    check_val("hit_at0", 64'(hit_at[31:0]), 64'd1234);
    check_val("hit_tick", 64'(tick), 64'd1);

    // Write to channel 1 at tick 1300, then a repeat read of channel 0
    wait_count(32'd1300, "wc1300");
    adr = 16'hFF50; n_wr = 1'b0;
    cyc();
    cyc();
    n_wr = 1'b1; adr = 16'h0000;
    wait_count(32'd1310, "wc1310");
    adr = 16'h0100; n_rd = 1'b0;
    cyc();
    cyc();
    n_rd = 1'b1; adr = 16'h0000;
    check_val("hit_both", 64'(hit), 64'h3);
    check_val("hit_at0_sticky", 64'(hit_at[31:0]), 64'd1234);
    check_val("hit_at1", 64'(hit_at[63:32]), 64'd1300);

    // Clear mid-run
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check_val("clr_count", 64'(count), 64'd0);
    check_val("clr_hit", 64'(hit), 64'd0);
    check_val("clr_running", 64'(running), 64'd0);
    check_val("clr_clkout", 64'(clkout), 64'd0);

    // Wrap of the 4-bit instance: 17 ticks -> 1
    pulse_start();
    wait_count(32'd17, "wc17");
    check_val("wrap4", 64'(s_count), 64'd1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;

    // Stop aligned to count[1:0] == 2, requested at count 13
    half_period = 4'd1;
    align = 2'd2;
    pulse_start();
    wait_count(32'd13, "wc13");
    stop_req = 1'b1;
    cyc();
    stop_req = 1'b0;
    wait_count(32'd14, "wc14");
    check_val("stop_tick_clkout", 64'(clkout), 64'd1);
    cyc();
    check_val("stop_hold_running", 64'(running), 64'd1);
    cyc();
    check_val("stop_clkout", 64'(clkout), 64'd0);
    check_val("stop_running", 64'(running), 64'd0);
    ticks_seen = 0;
    repeat (30) cyc();
    check_val("stop_no_ticks", 64'(ticks_seen), 64'd0);
    check_val("stop_count", 64'(count), 64'd14);

    // Single step while halted
    ticks_seen = 0;
    step = 1'b1;
    cyc();
    step = 1'b0;
`ifdef GBCLK_STEP_EN
    check_val("step_running", 64'(running), 64'd1);
    repeat (20) cyc();
    check_val("step_ticks", 64'(ticks_seen), 64'd1);
    check_val("step_count", 64'(count), 64'd15);
`else
    check_val("step_running", 64'(running), 64'd0);
    repeat (20) cyc();
    check_val("step_ticks", 64'(ticks_seen), 64'd0);
    check_val("step_count", 64'(count), 64'd14);
`endif
    check_val("step_clkout", 64'(clkout), 64'd0);
    check_val("step_idle", 64'(running), 64'd0);
    check_val("tick_align_all", 64'(tick_bad), 64'd0);

    // Asynchronous reset in the middle of a high phase
    pulse_start();
    wait_level(1'b1, "rst_rise");
    n_reset = 1'b0;
    #1;
    check_val("async_rst_clkout", 64'(clkout), 64'd0);
    check_val("async_rst_count", 64'(count), 64'd0);
    check_val("async_rst_running", 64'(running), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
